subleq_core: RTL and testbench

SUBLEQ_CORE -- requirements
Module: subleq_core

---
 rtl/subleq_core_if.sv | 27 ++
 rtl/subleq_core.sv | 145 ++++++++++++++
 tb/tb_subleq_core.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/subleq_core_if.sv
// Memory bus between the SUBLEQ core and its word-addressed memory.
//   mem_addr  : address of the current read or write
//   mem_rd_en : read strobe, mem_rdata returned exactly one cycle later
//   mem_rdata : read data
//   mem_wr_en : write strobe, memory stores mem_wdata at mem_addr on that edge
//   mem_wdata : write data
// master = core side, slave = memory side.
interface subleq_core_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8
);
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_en;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_wr_en;
   logic [DATA_W-1:0] mem_wdata;

   modport master (
      output mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/subleq_core.sv
// Single-instruction (SUBLEQ) processor core.
// Each instruction is three words a, b, c at pc..pc+2:
//   mem[b] <= mem[b] - mem[a]; branch to c if the result is <= 0, else pc+3.
// A taken branch whose target word has its MSB set halts the core.
// Ports:
//   clock, reset      : clock and synchronous active-high reset
//   start             : pulse to begin/resume execution at pc (IDLE/HALT only)
//   single_step       : pause in IDLE after the current instruction
//   mem               : memory bus (master modport), one access per cycle
//   busy, halted      : run status
//   pc, instr_count   : program counter, saturating completed-instruction count
module subleq_core #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned START_PC = 0,
   parameter int unsigned CNT_W    = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              single_step,
   subleq_core_if.master     mem,
   output logic              busy,
   output logic              halted,
   output logic [ADDR_W-1:0] pc,
   output logic [CNT_W-1:0]  instr_count
);

   typedef enum logic [2:0] {
      IDLE, F0, F1, F2, F3, F4, WB, HALT
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] a_addr;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] c_word;
   logic [DATA_W-1:0] a_val;
   logic [DATA_W-1:0] diff;
   logic              taken;
   logic [ADDR_W-1:0] addr_c;
   logic              rd_c;
   logic              wr_c;

   // In WB the read data on the bus is mem[b]
   assign diff  = mem.mem_rdata - a_val;
   assign taken = diff[DATA_W-1] | (diff == '0);

   always_comb begin
      addr_c = pc;
      rd_c   = 1'b0;
      wr_c   = 1'b0;
      case (state)
         F0: rd_c = 1'b1;
         F1: begin
            addr_c = pc + ADDR_W'(1);
            rd_c   = 1'b1;
         end
         F2: begin
            addr_c = pc + ADDR_W'(2);
            rd_c   = 1'b1;
         end
         F3: begin
            addr_c = a_addr;
            rd_c   = 1'b1;
         end
         F4: begin
            addr_c = b_addr;
            rd_c   = 1'b1;
         end
         WB: begin
            addr_c = b_addr;
            wr_c   = 1'b1;
         end
         default: ;
      endcase
   end

   // Strobes are gated by reset combinationally so a reset landing on WB
   // suppresses the write in that very cycle.
   assign mem.mem_addr  = addr_c;
   assign mem.mem_rd_en = rd_c & ~reset;
   assign mem.mem_wr_en = wr_c & ~reset;
   assign mem.mem_wdata = diff;

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         pc          <= ADDR_W'(START_PC);
         instr_count <= '0;
         busy        <= 1'b0;
         halted      <= 1'b0;
         a_addr      <= '0;
         b_addr      <= '0;
         c_word      <= '0;
         a_val       <= '0;
      end else begin
         case (state)
            IDLE, HALT: begin
               if (start) begin
                  state  <= F0;
                  busy   <= 1'b1;
                  halted <= 1'b0;
               end
            end
            F0: state <= F1;
            F1: begin
               a_addr <= mem.mem_rdata[ADDR_W-1:0];
               state  <= F2;
            end
            F2: begin
               b_addr <= mem.mem_rdata[ADDR_W-1:0];
               state  <= F3;
            end
            F3: begin
               c_word <= mem.mem_rdata;
               state  <= F4;
            end
            F4: begin
               a_val <= mem.mem_rdata;
               state <= WB;
            end
            WB: begin
               if (instr_count != '1)
                  instr_count <= instr_count + CNT_W'(1);
               if (taken && c_word[DATA_W-1]) begin
                  // Halt keeps pc on the halting instruction
                  state  <= HALT;
                  halted <= 1'b1;
                  busy   <= 1'b0;
               end else begin
                  pc <= taken ? c_word[ADDR_W-1:0] : pc + ADDR_W'(3);
                  if (single_step) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= F0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_subleq_core.sv
module tb_subleq_core;

   typedef struct {
      logic [7:0]  addr;
      logic [7:0]  data;
      int unsigned idx;
      logic [7:0]  pc;
      logic [15:0] cnt;
      logic        halt;
      logic        busy;
   } exp_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        single_step = 1'b0;
   logic        busy, halted;
   logic [7:0]  pc;
   logic [15:0] instr_count;

   logic        start1 = 1'b0;
   logic        busy1, halted1;
   logic [7:0]  pc1;
   logic [1:0]  cnt1;

   subleq_core_if #(.DATA_W(8), .ADDR_W(8)) bus ();
   subleq_core_if #(.DATA_W(8), .ADDR_W(8)) bus1 ();

   subleq_core #(.DATA_W(8), .ADDR_W(8), .START_PC(0), .CNT_W(16)) dut (
      .clock(clock), .reset(reset), .start(start), .single_step(single_step),
      .mem(bus), .busy(busy), .halted(halted), .pc(pc), .instr_count(instr_count)
   );

   subleq_core #(.DATA_W(8), .ADDR_W(8), .START_PC(254), .CNT_W(2)) dut1 (
      .clock(clock), .reset(reset), .start(start1), .single_step(1'b1),
      .mem(bus1), .busy(busy1), .halted(halted1), .pc(pc1), .instr_count(cnt1)
   );

   // Memories: one-cycle read latency, bulk load via load_req
   logic [7:0] mem [256];
   logic [7:0] mem1 [256];
   logic [7:0] mem_init [256];
   logic [7:0] mem1_init [256];
   logic       load_req = 1'b0;

   always @(posedge clock) begin
      if (load_req) begin
         mem  <= mem_init;
         mem1 <= mem1_init;
      end else begin
         if (bus.mem_wr_en)  mem[bus.mem_addr]   <= bus.mem_wdata;
         if (bus1.mem_wr_en) mem1[bus1.mem_addr] <= bus1.mem_wdata;
      end
      if (bus.mem_rd_en)  bus.mem_rdata  <= mem[bus.mem_addr];
      if (bus1.mem_rd_en) bus1.mem_rdata <= mem1[bus1.mem_addr];
   end

   int unsigned cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Reference model: instruction-level SUBLEQ on its own memory copy
   logic [7:0]  ref_mem [256];
   logic [7:0]  ref_pc;
   int unsigned ref_cnt;
   exp_t        sbq[$];
   exp_t        pend[$];
   int unsigned run_cyc;

   task automatic model_step(input int unsigned idx, output exp_t e);
      logic [7:0] p1, p2, a, b, c, res;
      bit tk;
      p1  = ref_pc + 8'd1;
      p2  = ref_pc + 8'd2;
      a   = ref_mem[ref_pc];
      b   = ref_mem[p1];
      c   = ref_mem[p2];
      res = ref_mem[b] - ref_mem[a];
      tk  = ($signed(res) <= 0);
      ref_mem[b] = res;
      if (ref_cnt < 65535) ref_cnt++;
      e.halt = tk && c[7];
      if (!e.halt) ref_pc = tk ? c : ref_pc + 8'd3;
      e.addr = b;
      e.data = res;
      e.idx  = idx;
      e.pc   = ref_pc;
      e.cnt  = 16'(ref_cnt);
      e.busy = 1'b0;
   endtask

   // Scoreboard monitor
   exp_t cur;
   bit   post_pend = 0;
   always @(negedge clock) begin
      if (post_pend) begin
         post_pend = 0;
         chk("post_pc", 32'(pc), 32'(cur.pc));
         chk("post_count", 32'(instr_count), 32'(cur.cnt));
         chk("post_halted", 32'(halted), 32'(cur.halt));
         chk("post_busy", 32'(busy), 32'(cur.busy));
      end
      if (bus.mem_rd_en || bus.mem_wr_en) begin
         checks++;
         if ((bus.mem_rd_en && bus.mem_wr_en) || reset) begin
            errors++;
            $display("FAIL strobes: rd=%0b wr=%0b reset=%0b", bus.mem_rd_en, bus.mem_wr_en, reset);
         end
      end
      if (bus.mem_wr_en) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %0h data %0h expected none", bus.mem_addr, bus.mem_wdata);
         end else begin
            cur = sbq.pop_front();
            chk("wr_addr", 32'(bus.mem_addr), 32'(cur.addr));
            chk("wr_data", 32'(bus.mem_wdata), 32'(cur.data));
            chk("wr_cycle", cyc, run_cyc + 5 + 6 * cur.idx);
            post_pend = 1;
         end
      end
   end

   logic [7:0] rdq[$];
   always @(negedge clock) if (bus1.mem_rd_en) rdq.push_back(bus1.mem_addr);

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      ref_pc  = 8'h00;
      ref_cnt = 0;
   endtask

   task automatic load_mem();
      @(negedge clock);
      load_req = 1'b1;
      @(posedge clock);
      #1;
      load_req = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      run_cyc = cyc;
   endtask

   task automatic wait_idle(input int maxc);
      int n = 0;
      @(negedge clock);
      while (busy && n < maxc) begin
         @(negedge clock);
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL timeout: busy still 1 after %0d cycles, expected 0", maxc);
      end
   endtask

   task automatic step1();
      exp_t e;
      model_step(0, e);
      e.busy = 1'b0;
      sbq.push_back(e);
      pulse_start();
      wait_idle(40);
   endtask

   // Model the current ref state until a halt (max 64 instructions)
   task automatic model_run(output bit ok);
      exp_t e;
      ok = 0;
      pend.delete();
      for (int n = 0; n < 64; n++) begin
         model_step(n, e);
         e.busy = 1'b1;
         pend.push_back(e);
         if (e.halt) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic launch_free();
      pend[pend.size()-1].busy = 1'b0;
      foreach (pend[i]) sbq.push_back(pend[i]);
      single_step = 1'b0;
      pulse_start();
      wait_idle(64 * 6 + 20);
   endtask

   task automatic free_run();
      logic [7:0]  pc0;
      int unsigned cnt0;
      bit          ok = 0;
      pc0  = ref_pc;
      cnt0 = ref_cnt;
      for (int t = 0; t < 20 && !ok; t++) begin
         for (int i = 0; i < 256; i++) mem_init[i] = 8'($urandom);
         ref_mem = mem_init;
         ref_pc  = pc0;
         ref_cnt = cnt0;
         model_run(ok);
      end
      if (ok) begin
         load_mem();
         launch_free();
         chk("free_halted", 32'(halted), 32'd1);
      end else begin
         ref_pc  = pc0;
         ref_cnt = cnt0;
      end
   endtask

   task automatic clear_init();
      for (int i = 0; i < 256; i++) mem_init[i] = 8'h00;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      logic [7:0] exp_rd [5];
      exp_rd = '{8'hFE, 8'hFF, 8'h00, 8'h10, 8'h11};
      for (int i = 0; i < 256; i++) mem1_init[i] = 8'h00;
      mem1_init[8'hFE] = 8'h10;
      mem1_init[8'hFF] = 8'h11;
      mem1_init[8'h00] = 8'h40;
      mem1_init[8'h10] = 8'h01;
      mem1_init[8'h11] = 8'h05;
      clear_init();
      load_mem();

      // Reset state
      do_reset();
      @(negedge clock);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_pc", 32'(pc), 32'h00);
      chk("rst_count", 32'(instr_count), 32'd0);
      chk("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
      chk("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
      chk("rst_pc1", 32'(pc1), 32'hFE);

      // Two-instruction program ending in halt
      clear_init();
      mem_init[0] = 8'h09; mem_init[1] = 8'h0A; mem_init[2] = 8'h03;
      mem_init[3] = 8'h0A; mem_init[4] = 8'h0A; mem_init[5] = 8'hFF;
      mem_init[9] = 8'h02; mem_init[10] = 8'h05;
      ref_mem = mem_init;
      load_mem();
      model_run(ok);
      launch_free();
      chk("prog_halted", 32'(halted), 32'd1);
      chk("prog_pc", 32'(pc), 32'h03);
      chk("prog_count", 32'(instr_count), 32'd2);
      chk("prog_mem10", 32'(mem[10]), 32'h00);

      // Single-step directed cases
      single_step = 1'b1;
      do_reset();
      clear_init();
      mem_init[0] = 8'h50; mem_init[1] = 8'h51; mem_init[2] = 8'h40;
      mem_init[3] = 8'h52; mem_init[4] = 8'h53; mem_init[5] = 8'h20;
      mem_init[8'h20] = 8'h54; mem_init[8'h21] = 8'h54; mem_init[8'h22] = 8'h06;
      mem_init[6] = 8'h60; mem_init[7] = 8'h61; mem_init[8] = 8'h00;
      mem_init[8'h50] = 8'h01; mem_init[8'h51] = 8'h80;
      mem_init[8'h52] = 8'h01; mem_init[8'h53] = 8'h00;
      mem_init[8'h54] = 8'h07;
      mem_init[8'h60] = 8'h01; mem_init[8'h61] = 8'h09;
      ref_mem = mem_init;
      load_mem();
      step1();
      chk("notaken_mem", 32'(mem[8'h51]), 32'h7F);
      chk("notaken_pc", 32'(pc), 32'h03);
      chk("step_halted", 32'(halted), 32'd0);
      step1();
      chk("taken_mem", 32'(mem[8'h53]), 32'hFF);
      chk("taken_pc", 32'(pc), 32'h20);
      chk("taken_halted", 32'(halted), 32'd0);
      step1();
      chk("aeqb_mem", 32'(mem[8'h54]), 32'h00);
      chk("aeqb_pc", 32'(pc), 32'h06);

      // Reset landing on the WB cycle
      pulse_start();
      repeat (5) @(posedge clock);
      #1;
      reset = 1'b1;
      @(negedge clock);
      chk("wbrst_wr_en", 32'(bus.mem_wr_en), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      chk("wbrst_mem", 32'(mem[8'h61]), 32'h09);
      chk("wbrst_pc", 32'(pc), 32'h00);
      chk("wbrst_busy", 32'(busy), 32'd0);
      chk("wbrst_count", 32'(instr_count), 32'd0);
      ref_pc  = 8'h00;
      ref_cnt = 0;

      // Random single-step run
      for (int i = 0; i < 256; i++) mem_init[i] = 8'($urandom);
      ref_mem = mem_init;
      load_mem();
      for (int s = 0; s < 40; s++) step1();

      // Random free-running programs, resuming from halt
      for (int r = 0; r < 6; r++) free_run();

      // START_PC=FE instance: address wrap and saturating count
      do_reset();
      load_mem();
      rdq.delete();
      for (int k = 1; k <= 5; k++) begin
         int n = 0;
         @(negedge clock);
         start1 = 1'b1;
         @(posedge clock);
         #1;
         start1 = 1'b0;
         @(negedge clock);
         while (busy1 && n < 40) begin
            @(negedge clock);
            n++;
         end
         chk("wrap_busy", 32'(busy1), 32'd0);
         chk("wrap_count", 32'(cnt1), (k < 3) ? 32'(k) : 32'd3);
         if (k == 1) begin
            chk("wrap_nreads", rdq.size(), 32'd5);
            for (int j = 0; j < 5 && j < rdq.size(); j++)
               chk("wrap_fetch_addr", 32'(rdq[j]), 32'(exp_rd[j]));
            chk("wrap_mem", 32'(mem1[8'h11]), 32'h04);
            chk("wrap_pc", 32'(pc1), 32'h01);
            chk("wrap_halted", 32'(halted1), 32'd0);
         end
      end

      repeat (3) @(negedge clock);
      chk("sb_empty", sbq.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
